// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=4 convolutional encoder with frame/tail/gap sequencing.
// Feeds the Viterbi decoder's symbol input and enable.
module conv_encoder_framer #(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter logic [3:0]  G0         = 4'b1111,
  parameter logic [3:0]  G1         = 4'b1101,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        frame_abort,
  output logic [1:0]  enc_out,
  output logic        enc_valid,
  output logic        frame_last,
  output logic        stall_seen,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_TAIL, S_GAP
  } state_t;

  localparam logic [15:0] LEN_C = 16'(FRAME_LEN);
  localparam logic [15:0] GAP_C = 16'(GAP_CYCLES);

  state_t      state;
  logic [2:0]  s;
  logic [15:0] cnt;
  logic [1:0]  tail_cnt;
  logic [15:0] gap_cnt;
  logic        ready_q;
  logic        take;

  // abort must block a transfer in the very cycle it is raised
  assign bit_ready = ready_q & ~frame_abort;
  assign take      = bit_valid & bit_ready;

  function automatic logic [1:0] encode(
    input logic       b,
    input logic [2:0] sr
  );
    logic [3:0] v;
    v = {b, sr[0], sr[1], sr[2]};
    return {^(v & G0), ^(v & G1)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      s           <= 3'b000;
      cnt         <= 16'd0;
      tail_cnt    <= 2'd0;
      gap_cnt     <= 16'd0;
      ready_q     <= 1'b0;
      enc_out     <= 2'b00;
      enc_valid   <= 1'b0;
      frame_last  <= 1'b0;
      stall_seen  <= 1'b0;
      frame_count <= 16'd0;
    end else if (frame_abort) begin
      state      <= S_IDLE;
      s          <= 3'b000;
      cnt        <= 16'd0;
      tail_cnt   <= 2'd0;
      gap_cnt    <= 16'd0;
      ready_q    <= 1'b1;
      enc_valid  <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      enc_valid  <= 1'b0;
      frame_last <= 1'b0;
      unique case (state)
        S_IDLE, S_DATA: begin
          ready_q <= 1'b1;
          if (take) begin
            enc_out   <= encode(bit_in, s);
            enc_valid <= 1'b1;
            s         <= {s[1:0], bit_in};
            if (cnt + 16'd1 == LEN_C) begin
              state    <= S_TAIL;
              cnt      <= 16'd0;
              tail_cnt <= 2'd0;
              ready_q  <= 1'b0;
            end else begin
              state <= S_DATA;
              cnt   <= cnt + 16'd1;
            end
          end else if (state == S_DATA) begin
            stall_seen <= 1'b1;
          end
        end
        S_TAIL: begin
          ready_q   <= 1'b0;
          enc_out   <= encode(1'b0, s);
          enc_valid <= 1'b1;
          s         <= {s[1:0], 1'b0};
          tail_cnt  <= tail_cnt + 2'd1;
          if (tail_cnt == 2'd2) begin
            frame_last  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            tail_cnt    <= 2'd0;
            gap_cnt     <= 16'd0;
            state       <= (GAP_C == 16'd0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          // ready rises one cycle after IDLE is re-entered
          ready_q <= 1'b0;
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_cnt + 16'd1 == GAP_C) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer: two instances (len 4/gap 2, len 1/gap 0)
// checked every cycle against a timestamp-based behavioural model.
module tb_conv_encoder_framer;

  localparam int LEN_A = 4;
  localparam int GAP_A = 2;
  localparam int LEN_B = 1;
  localparam int GAP_B = 0;

  logic        clk;
  logic        rst;
  logic [1:0]  bit_in;
  logic [1:0]  bit_valid;
  logic [1:0]  frame_abort;
  logic [1:0]  bit_ready;
  logic [1:0]  enc_valid;
  logic [1:0]  frame_last;
  logic [1:0]  stall_seen;
  logic [1:0]  enc_out [2];
  logic [15:0] frame_count [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wrap_seq = 0;

  conv_encoder_framer #(
    .FRAME_LEN(LEN_A), .G0(4'b1111), .G1(4'b1101), .GAP_CYCLES(GAP_A)
  ) dut_a (
    .clk(clk), .rst(rst),
    .bit_in(bit_in[0]), .bit_valid(bit_valid[0]),
    .bit_ready(bit_ready[0]), .frame_abort(frame_abort[0]),
    .enc_out(enc_out[0]), .enc_valid(enc_valid[0]),
    .frame_last(frame_last[0]), .stall_seen(stall_seen[0]),
    .frame_count(frame_count[0])
  );

  conv_encoder_framer #(
    .FRAME_LEN(LEN_B), .G0(4'b1111), .G1(4'b1101), .GAP_CYCLES(GAP_B)
  ) dut_b (
    .clk(clk), .rst(rst),
    .bit_in(bit_in[1]), .bit_valid(bit_valid[1]),
    .bit_ready(bit_ready[1]), .frame_abort(frame_abort[1]),
    .enc_out(enc_out[1]), .enc_valid(enc_valid[1]),
    .frame_last(frame_last[1]), .stall_seen(stall_seen[1]),
    .frame_count(frame_count[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_len [2];
  int          m_gap [2];
  int          e [2];
  int          ready_from [2];
  int          tail_start [2];
  int          cnt [2];
  logic [2:0]  hist [2];
  logic [1:0]  m_out [2];
  logic        m_valid [2];
  logic        m_last [2];
  logic        m_stall [2];
  logic [15:0] m_count [2];
  int          wrap_seen;

  function automatic logic par(input logic [3:0] g, input logic b,
                               input logic [2:0] h);
    logic [3:0] taps;
    logic p;
    taps = {b, h[0], h[1], h[2]};
    p = 1'b0;
    for (int k = 0; k < 4; k++)
      if (g[k]) p = p ^ taps[k];
    return p;
  endfunction

  task automatic emit(input int i, input logic b);
    m_out[i]   = {par(4'b1111, b, hist[i]), par(4'b1101, b, hist[i])};
    m_valid[i] = 1'b1;
    hist[i]    = {hist[i][1:0], b};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      e[i] = 0;
      ready_from[i] = 1;
      tail_start[i] = -100;
      cnt[i] = 0;
      hist[i] = 3'b000;
      m_out[i] = 2'b00;
      m_valid[i] = 1'b0;
      m_last[i] = 1'b0;
      m_stall[i] = 1'b0;
      m_count[i] = 16'd0;
    end
  endtask

  initial begin
    logic rdy;
    m_len[0] = LEN_A; m_gap[0] = GAP_A;
    m_len[1] = LEN_B; m_gap[1] = GAP_B;
    wrap_seen = 0;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        if (wrap_seq != wrap_seen) begin
          wrap_seen = wrap_seq;
          m_count[1] = 16'hffff;
        end
        for (int i = 0; i < 2; i++) begin
          rdy = (e[i] >= ready_from[i]) && !frame_abort[i];
          if (frame_abort[i]) begin
            hist[i] = 3'b000;
            cnt[i] = 0;
            tail_start[i] = -100;
            m_valid[i] = 1'b0;
            m_last[i] = 1'b0;
            ready_from[i] = e[i] + 1;
          end else if (e[i] >= tail_start[i] && e[i] <= tail_start[i] + 2) begin
            emit(i, 1'b0);
            m_last[i] = (e[i] == tail_start[i] + 2);
            if (m_last[i]) m_count[i] = m_count[i] + 16'd1;
          end else if (rdy && bit_valid[i]) begin
            emit(i, bit_in[i]);
            m_last[i] = 1'b0;
            cnt[i]++;
            if (cnt[i] == m_len[i]) begin
              cnt[i] = 0;
              tail_start[i] = e[i] + 1;
              ready_from[i] = e[i] + m_gap[i] + 5;
            end
          end else begin
            m_valid[i] = 1'b0;
            m_last[i] = 1'b0;
            if (cnt[i] > 0 && !bit_valid[i]) m_stall[i] = 1'b1;
          end
          e[i]++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] log0 [$];
  logic [1:0] log1 [$];

  initial forever begin
    logic exp_rdy;
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_rdy = !rst && (e[i] >= ready_from[i]) && !frame_abort[i];
      check($sformatf("enc_valid[%0d]", i), int'(enc_valid[i]), int'(m_valid[i]));
      check($sformatf("enc_out[%0d]", i), int'(enc_out[i]), int'(m_out[i]));
      check($sformatf("frame_last[%0d]", i), int'(frame_last[i]), int'(m_last[i]));
      check($sformatf("stall_seen[%0d]", i), int'(stall_seen[i]), int'(m_stall[i]));
      check($sformatf("frame_count[%0d]", i), int'(frame_count[i]), int'(m_count[i]));
      check($sformatf("bit_ready[%0d]", i), int'(bit_ready[i]), int'(exp_rdy));
    end
    if (enc_valid[0]) log0.push_back(enc_out[0]);
    if (enc_valid[1]) log1.push_back(enc_out[1]);
  end

  // ---------------- stimulus ----------------
  int acc_cyc;

  task automatic send(input int i, input logic b);
    int k;
    logic acc;
    k = 0;
    bit_valid[i] = 1'b1;
    bit_in[i] = b;
    forever begin
      #2;
      acc = bit_ready[i];
      @(negedge clk);
      if (acc) break;
      k++;
      if (k > 40) begin
        check("send_timeout", k, 0);
        break;
      end
    end
    acc_cyc = cyc;
    bit_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_log(input string name, input int i, input int start,
                           input int exp[7], input int n);
    int sz;
    sz = (i == 0) ? log0.size() : log1.size();
    check({name, "_len"}, sz - start, n);
    for (int k = 0; k < n; k++)
      if (start + k < sz)
        check($sformatf("%s_sym%0d", name, k),
              int'((i == 0) ? log0[start + k] : log1[start + k]), exp[k]);
  endtask

  initial begin
    int trellis[7];
    int len1[7];
    int st;
    int t4;
    trellis = '{3, 3, 1, 3, 1, 1, 3};
    len1 = '{3, 3, 2, 3, 0, 0, 0};
    rst = 1'b1;
    bit_in = 2'b00;
    bit_valid = 2'b00;
    frame_abort = 2'b00;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    #1 check("ready_after_rst", int'(bit_ready[0]), 0);
    @(posedge clk);
    #1 check("ready_first_edge", int'(bit_ready[0]), 1);
    @(negedge clk);

    // trellis vectors
    st = log0.size();
    send(0, 1'b1); send(0, 1'b0); send(0, 1'b1); send(0, 1'b1);
    idle(8);
    check_log("trellis", 0, st, trellis, 7);
    check("trellis_count", int'(frame_count[0]), 1);

    // single-bit frame, no gap
    st = log1.size();
    send(1, 1'b1);
    idle(6);
    check_log("len1", 1, st, len1, 4);
    check("len1_count", int'(frame_count[1]), 1);

    // continuous valid across frame boundary
    for (int k = 0; k < 8; k++) begin
      send(0, 1'($urandom));
      if (k == 3) t4 = acc_cyc;
      if (k == 4) check("backpressure_gap", acc_cyc - t4, 3 + GAP_A + 2);
    end
    idle(8);
    check("stall_before_bubble", int'(stall_seen[0]), 0);

    // bubble inside frame
    st = log0.size();
    send(0, 1'b1); send(0, 1'b0);
    idle(3);
    send(0, 1'b1); send(0, 1'b1);
    idle(8);
    check_log("bubble", 0, st, trellis, 7);
    check("stall_after_bubble", int'(stall_seen[0]), 1);

    // abort after two bits
    send(0, 1'b1); send(0, 1'b0);
    frame_abort[0] = 1'b1;
    bit_valid[0] = 1'b1;
    bit_in[0] = 1'b1;
    #2 check("abort_ready", int'(bit_ready[0]), 0);
    @(negedge clk);
    frame_abort[0] = 1'b0;
    bit_valid[0] = 1'b0;
    #2 check("abort_valid", int'(enc_valid[0]), 0);
    idle(2);
    st = log0.size();
    send(0, 1'b1); send(0, 1'b0); send(0, 1'b1); send(0, 1'b1);
    idle(8);
    check_log("post_abort", 0, st, trellis, 7);

    // random traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        frame_abort[i] = ($urandom_range(0, 39) == 0);
        bit_valid[i] = ($urandom_range(0, 3) != 0);
        bit_in[i] = 1'($urandom);
      end
    end
    @(negedge clk);
    bit_valid = 2'b00;
    frame_abort = 2'b11;
    @(negedge clk);
    frame_abort = 2'b00;
    idle(4);

    // frame_count wrap
    #3 force dut_b.frame_count = 16'hffff;
    wrap_seq++;
    @(posedge clk);
    #1 release dut_b.frame_count;
    @(negedge clk);
    send(1, 1'b1);
    idle(6);
    check("wrap_count", int'(frame_count[1]), 0);

    // asynchronous reset during the tail
    send(0, 1'b0); send(0, 1'b1); send(0, 1'b1); send(0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_valid", int'(enc_valid[0]), 0);
    check("rst_out", int'(enc_out[0]), 0);
    check("rst_last", int'(frame_last[0]), 0);
    check("rst_stall", int'(stall_seen[0]), 0);
    check("rst_count", int'(frame_count[0]), 0);
    check("rst_ready", int'(bit_ready[0]), 0);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check("ready_after_rst2", int'(bit_ready[0]), 0);
    @(posedge clk);
    #1 check("ready_first_edge2", int'(bit_ready[0]), 1);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
